req_arbiter_8x3: RTL
====================

REQ_ARBITER_8X3 -- requirements
Module: req_arbiter_8x3

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive grant cycles per owner; legal range 2..256; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  arbitration enable; low blocks new grants.
REQ-005 req  input  8  per-requester request, level, held high for the whole tenure.
REQ-006 gnt  output  8  one-hot grant, registered.
REQ-007 gnt_id  output  3  binary index of the granted requester, registered.
REQ-008 gnt_valid  output  1  high when gnt is non-zero.
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-revoked.

Function
REQ-010 The block SHALL implement two states: IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-011 Winner selection SHALL be round-robin: the first asserted req bit searching upward from ptr, wrapping 7->0.
REQ-012 ptr SHALL update to (winner+1) mod 8 on every edge that issues a grant; 7 wraps to 0.
REQ-013 IDLE: if en=1 and req!=0 at an edge, the block SHALL enter GRANT with the winner registered; latency from req to gnt is exactly 1 cycle.
REQ-014 IDLE with en=0 or req=0 SHALL stay IDLE.
REQ-015 GRANT: while req[gnt_id]=1 (and no timeout), gnt, gnt_id and ptr SHALL hold.
REQ-016 GRANT: on the edge where req[gnt_id]=0, if en=1 and another req is set, the block SHALL grant the next winner on that edge with no idle bubble; otherwise it SHALL return to IDLE.
REQ-017 en falling during GRANT SHALL NOT revoke the current grant; only re-arbitration is suppressed.
REQ-018 gnt_id SHALL equal the encoded position of the gnt bit whenever gnt_valid=1, and SHALL be 0 when gnt_valid=0.
REQ-019 Request changes on non-owners during GRANT SHALL have no effect until the owner releases.
REQ-020 A requester that raises req in the same cycle the owner releases SHALL be eligible in that arbitration.

Reset
REQ-021 rst_n low SHALL immediately force gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, state IDLE, hold counter 0.
REQ-022 Reset asserted mid-tenure SHALL drop the grant asynchronously; after release, the first arbitration starts from ptr=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN SHALL compile in the hold counter (8 bits).
REQ-024 With ARB_TIMEOUT_EN: the counter SHALL clear on each new grant and increment each GRANT cycle; at the edge ending the MAX_HOLD-th cycle the grant SHALL be revoked, timeout SHALL pulse for 1 cycle, and re-arbitration per REQ-016 SHALL occur with the revoked owner lowest priority (re-grant only if it is the sole requester and en=1).
REQ-025 Without ARB_TIMEOUT_EN: no counter, timeout SHALL be tied 0, tenure SHALL be unbounded, and the port list SHALL be unchanged.

Structure
REQ-026 A shared package arb_pkg SHALL hold N_REQ=8, ID_W=3, state encodings IDLE/GRANT, and the hold-counter width.
REQ-027 Winner selection SHALL use one sub-module, rr_prio_enc_8x3: an 8-bit rotated priority encoder (inputs req, ptr; outputs 3-bit index and any-valid), purely combinational.
REQ-028 All registers SHALL be in req_arbiter_8x3; outputs SHALL come directly from flops.

Verification
REQ-029 Reset, then req=8'h01, en=1 -> gnt=8'h01, gnt_id=0 one cycle later; ptr becomes 1.
REQ-030 req=8'hFF constant, each owner drops req for one cycle after a 2-cycle tenure -> grant order 0,1,...,7,0 with no idle cycles between tenures.
REQ-031 Owner 7 releases while req=8'h81 -> next grant is 0 (wrap), gnt=8'h01.
REQ-032 en=0 with req=8'h10 for 5 cycles -> gnt stays 0; en=1 -> gnt=8'h10 next cycle; en=0 mid-tenure -> grant held.
REQ-033 ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h06 held -> owner 1 for 4 cycles, timeout pulse, owner 2 for 4 cycles, timeout pulse, then owner 1.
REQ-034 rst_n asserted mid-tenure of owner 5 -> gnt=0 asynchronously; after release with req=8'h21, grant goes to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state encoding and helpers for the 8-way arbiter
//
// Purpose : Shared definitions for req_arbiter_8x3 and rr_prio_enc_8x3.
// Contents: N_REQ    - number of requesters
//           ID_W     - width of a requester index
//           HOLD_W   - width of the tenure (hold) counter
//           arb_state_e - IDLE / GRANT
//           id_to_onehot - index to one-hot grant vector

package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int ID_W   = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_prio_enc_8x3.sv
// rtl/rr_prio_enc_8x3.sv - rotated 8-input priority encoder for round-robin selection
//
// Purpose : Finds the first asserted request searching upward from ptr_i,
//           wrapping 7 -> 0. Purely combinational.
// Ports   : req_i   [7:0] in  - request vector
//           ptr_i   [2:0] in  - highest-priority position
//           idx_o   [2:0] out - index of the selected request (0 when none)
//           valid_o       out - at least one request is asserted

module rr_prio_enc_8x3
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the last hit,
  // i.e. the one closest to ptr_i, is the one that sticks.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr_i + ID_W'(i);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter_8x3.sv
// rtl/req_arbiter_8x3.sv - 8-requester round-robin arbiter with registered one-hot grant
//
// Purpose : Grants one of eight level requesters at a time. A grant is held
//           for as long as its owner keeps req high; on release the next
//           round-robin winner is granted on the same edge (no idle bubble).
//           Optional macro ARB_TIMEOUT_EN adds an 8-bit hold counter that
//           force-revokes a tenure after MAX_HOLD cycles and pulses timeout.
// Params  : MAX_HOLD (2..256) - tenure limit, only used with ARB_TIMEOUT_EN
// Ports   : clk             in  - rising-edge clock
//           rst_n           in  - asynchronous active-low reset
//           en              in  - arbitration enable, gates new grants only
//           req       [7:0] in  - per-requester level request
//           gnt       [7:0] out - one-hot grant (registered)
//           gnt_id    [2:0] out - index of the granted requester, 0 when idle
//           gnt_valid       out - gnt is non-zero
//           timeout         out - one-cycle pulse on a forced revoke

module req_arbiter_8x3
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("req_arbiter_8x3: MAX_HOLD must be within 2..256");
  end

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             gnt_valid_q;
  logic [ID_W-1:0]  ptr_q;

  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic             owner_req;
  logic             expire;
  logic             arb_now;
  logic             take_grant;

  // In GRANT, ptr_q already sits one past the owner, so a revoked owner that
  // is still requesting naturally lands last in the search order.
  rr_prio_enc_8x3 u_prio_enc (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (win_id),
    .valid_o (win_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;

  // hold_q counts completed GRANT cycles; it reads MAX_HOLD-1 during the
  // MAX_HOLD-th cycle of the tenure.
  assign expire  = (state_q == GRANT) && (hold_q == HOLD_LAST);
  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign owner_req = req[gnt_id_q];

  always_comb begin
    arb_now    = (state_q == IDLE) || !owner_req || expire;
    take_grant = arb_now && en && win_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      // Only a revoke of an owner that still wants the bus counts as forced.
      timeout_q <= expire && owner_req;
`endif
      if (take_grant) begin
        state_q     <= GRANT;
        gnt_q       <= id_to_onehot(win_id);
        gnt_id_q    <= win_id;
        gnt_valid_q <= 1'b1;
        ptr_q       <= win_id + ID_W'(1);
`ifdef ARB_TIMEOUT_EN
        hold_q      <= '0;
`endif
      end else if (arb_now) begin
        state_q     <= IDLE;
        gnt_q       <= '0;
        gnt_id_q    <= '0;
        gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_q      <= '0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
        hold_q      <= hold_q + HOLD_W'(1);
`endif
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule
